rr_arb_mux4: RTL and testbench

Four-input round-robin arbiter plus one-entry output register that shares a single downstream val/rdy port between four val/rdy requesters. It sequences a 4:1 multiplexer of width p_nbits: each cycle it picks one valid requester, drives the mux select, and captures the selected message into an output buffer. It sits in front of any shared resource (memory port, network link, functional unit) fed by multiple producers.

---
 rtl/rr_arb_mux4.sv | 131 +++++++++++++
 tb/tb_rr_arb_mux4.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux4.sv
// rr_arb_mux4: four-input round-robin arbiter feeding a one-entry output
// register. Shares one downstream val/rdy port between four requesters by
// steering a 4:1 message mux and buffering the winner's message.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Ready may depend combinationally on valid, but valid must never
// depend on ready. Once valid is raised the message should stay stable until
// the transfer. A requester that drops valid early simply loses the grant.

module rr_arb_mux4 #(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,      // asynchronous, active-low
  input  logic [3:0]         in_val,
  output logic [3:0]         in_rdy,
  input  logic [p_nbits-1:0] in_msg0,
  input  logic [p_nbits-1:0] in_msg1,
  input  logic [p_nbits-1:0] in_msg2,
  input  logic [p_nbits-1:0] in_msg3,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out_msg,
  output logic [1:0]         out_src,
  output logic               dbg_state,  // output buffer state: 0 EMPTY, 1 FULL
  output logic [1:0]         dbg_ptr     // current priority pointer
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

  buf_state_t         state;
  buf_state_t         state_next;
  logic [1:0]         ptr;
  logic [1:0]         cand;
  logic [1:0]         gnt_idx;
  logic               gnt_found;
  logic               en;
  logic               in_xfer;
  logic [p_nbits-1:0] sel_msg;

  // The buffer can accept when it is empty or is being drained this cycle.
  assign en = (state == EMPTY) || out_rdy;

  // Nothing is accepted while reset is held, regardless of in_val.
  assign in_xfer = gnt_found && en && reset;

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = ptr;
    cand      = ptr;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!gnt_found && in_val[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Ready goes only to the winner, and only when the buffer can take it.
  always_comb begin
    in_rdy = 4'b0000;
    if (in_xfer) begin
      in_rdy[gnt_idx] = 1'b1;
    end
  end

  // 4:1 message mux steered by the grant.
  always_comb begin
    sel_msg = in_msg0;
    case (gnt_idx)
      2'd0:    sel_msg = in_msg0;
      2'd1:    sel_msg = in_msg1;
      2'd2:    sel_msg = in_msg2;
      default: sel_msg = in_msg3;
    endcase
  end

  // Buffer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Buffer next state: a fill wins over a drain, so a simultaneous
  // drain and fill keeps the buffer full with no bubble.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_next = FULL;
        end
      end
      FULL: begin
        if (in_xfer) begin
          state_next = FULL;
        end else if (out_rdy) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Capture the winner's message and rotate priority past the winner.
  // A stalled grant leaves ptr alone so priority is not lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr     <= 2'd0;
      out_msg <= '0;
      out_src <= 2'd0;
    end else if (in_xfer) begin
      ptr     <= gnt_idx + 2'd1;
      out_msg <= sel_msg;
      out_src <= gnt_idx;
    end
  end

  assign out_val   = (state == FULL);
  assign dbg_state = state;
  assign dbg_ptr   = ptr;

endmodule

// File: tb/tb_rr_arb_mux4.sv
// Bench for rr_arb_mux4: directed vectors with hand-computed grants and a
// seeded random phase, checked through an expected-message queue.

module tb_rr_arb_mux4;

  logic        clk;
  logic        reset;
  logic [3:0]  in_val;
  logic [3:0]  in_rdy;
  logic [31:0] m [4];
  logic [31:0] in_msg0, in_msg1, in_msg2, in_msg3;
  logic        out_val;
  logic        out_rdy;
  logic [31:0] out_msg;
  logic [1:0]  out_src;
  logic        dbg_state;
  logic [1:0]  dbg_ptr;

  logic [33:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  assign in_msg0 = m[0];
  assign in_msg1 = m[1];
  assign in_msg2 = m[2];
  assign in_msg3 = m[3];

  rr_arb_mux4 #(.p_nbits(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_msg0   (in_msg0),
    .in_msg1   (in_msg1),
    .in_msg2   (in_msg2),
    .in_msg3   (in_msg3),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out_msg   (out_msg),
    .out_src   (out_src),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, queue depth %0d", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh_idx(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  // One directed cycle: check the combinational grant and registered state at
  // the falling edge, queue the message that should be accepted, then step.
  task automatic cyc(input logic [3:0] e_rdy, input logic e_oval,
                     input logic [1:0] e_src, input logic [1:0] e_ptr);
    logic [1:0] w;
    @(negedge clk);
    chk("in_rdy", in_rdy, e_rdy);
    chk("out_val", out_val, e_oval);
    chk("dbg_state", dbg_state, e_oval);
    chk("ptr", dbg_ptr, e_ptr);
    if (e_oval) begin
      chk("out_src", out_src, e_src);
      chk("out_msg", out_msg, m[e_src]);
    end
    if (e_rdy != 4'b0000) begin
      w = oh_idx(e_rdy);
      exp_q.push_back({w, m[w]});
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output transfer must match the head of the queue.
  always @(negedge clk) begin
    if (reset && out_val && out_rdy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL out_xfer: got src %0d msg %0h expected nothing queued", out_src, out_msg);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        chk("out_xfer", {30'd0, out_src, out_msg}, {30'd0, e});
      end
    end
  end

  // Stimulus.
  logic       r_found;
  logic       r_en;
  logic       r_oval;
  logic [1:0] r_ptr;
  logic [1:0] r_g;
  logic [1:0] r_idx;
  logic [3:0] r_rdy;
  logic       r_granted;
  int         wait_cnt [4];

  initial begin
    reset   = 1'b0;
    in_val  = 4'b1111;
    out_rdy = 1'b0;
    m[0] = 32'h1111_0000;
    m[1] = 32'h2222_0001;
    m[2] = 32'h0000_CAFE;
    m[3] = 32'h4444_0003;

    // Reset held: nothing ready, buffer empty.
    cyc(4'b0000, 1'b0, 2'd0, 2'd0);
    chk("reset_out_msg", out_msg, 32'h0);
    chk("reset_out_src", out_src, 2'd0);
    reset = 1'b1;
    cyc(4'b0001, 1'b0, 2'd0, 2'd0);
    cyc(4'b0000, 1'b1, 2'd0, 2'd1);
    in_val = 4'b0000; out_rdy = 1'b1;
    cyc(4'b0000, 1'b1, 2'd0, 2'd1);

    // Single requester.
    in_val = 4'b0100;
    cyc(4'b0100, 1'b0, 2'd0, 2'd1);
    in_val = 4'b0000;
    cyc(4'b0000, 1'b1, 2'd2, 2'd3);

    // Round robin with every requester valid, no bubbles.
    in_val = 4'b1111;
    cyc(4'b1000, 1'b0, 2'd0, 2'd3);
    cyc(4'b0001, 1'b1, 2'd3, 2'd0);
    cyc(4'b0010, 1'b1, 2'd0, 2'd1);
    cyc(4'b0100, 1'b1, 2'd1, 2'd2);
    cyc(4'b1000, 1'b1, 2'd2, 2'd3);
    cyc(4'b0001, 1'b1, 2'd3, 2'd0);
    cyc(4'b0010, 1'b1, 2'd0, 2'd1);

    // Backpressure: full with src 1, stall five cycles, then release.
    out_rdy = 1'b0;
    repeat (5) cyc(4'b0000, 1'b1, 2'd1, 2'd2);
    out_rdy = 1'b1;
    cyc(4'b0100, 1'b1, 2'd1, 2'd2);
    in_val = 4'b0000;
    cyc(4'b0000, 1'b1, 2'd2, 2'd3);

    // Wrap and skip.
    in_val = 4'b0011;
    cyc(4'b0001, 1'b0, 2'd0, 2'd3);
    cyc(4'b0010, 1'b1, 2'd0, 2'd1);
    cyc(4'b0001, 1'b1, 2'd1, 2'd2);
    in_val = 4'b0100;
    cyc(4'b0100, 1'b1, 2'd0, 2'd1);
    in_val = 4'b1000;
    cyc(4'b1000, 1'b1, 2'd2, 2'd3);
    in_val = 4'b0000;
    cyc(4'b0000, 1'b1, 2'd3, 2'd0);

    // Reset mid-operation discards the buffered message immediately.
    in_val = 4'b0001; out_rdy = 1'b0;
    cyc(4'b0001, 1'b0, 2'd0, 2'd0);
    reset = 1'b0;
    #1;
    chk("midrst_out_val", out_val, 1'b0);
    chk("midrst_ptr", dbg_ptr, 2'd0);
    chk("midrst_in_rdy", in_rdy, 4'b0000);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset  = 1'b1;
    in_val = 4'b0000;

    // Seeded random traffic; requesters hold valid until accepted.
    void'($urandom(32'd2024));
    r_ptr  = 2'd0;
    r_oval = 1'b0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!in_val[i] && $urandom_range(0, 2) != 0) begin
          in_val[i] = 1'b1;
          m[i] = $urandom;
        end
      end
      out_rdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      r_en    = !r_oval || out_rdy;
      r_found = 1'b0;
      r_g     = 2'd0;
      for (int k = 0; k < 4; k++) begin
        r_idx = r_ptr + 2'(k);
        if (!r_found && in_val[r_idx]) begin
          r_found = 1'b1;
          r_g     = r_idx;
        end
      end
      r_granted = r_found && r_en;
      r_rdy = r_granted ? (4'b0001 << r_g) : 4'b0000;
      chk("rand_in_rdy", in_rdy, r_rdy);
      if (r_granted) begin
        exp_q.push_back({r_g, m[r_g]});
        chk("rand_fair_wait", 64'(wait_cnt[r_g] <= 3), 64'd1);
        for (int i = 0; i < 4; i++) if (i != int'(r_g) && in_val[i]) wait_cnt[i]++;
        wait_cnt[r_g] = 0;
        r_ptr  = r_g + 2'd1;
        r_oval = 1'b1;
      end else if (r_oval && out_rdy) begin
        r_oval = 1'b0;
      end
      @(posedge clk);
      #1;
      if (r_granted) in_val[r_g] = 1'b0;
    end

    // Drain and confirm every accepted message came out.
    in_val  = 4'b0000;
    out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
